// File: rtl/alu_exception_unit.sv
// Exception detector for committed ALU ops: captures cause/EPC, requests the trap
// handler, counts exceptions lost while busy and keeps sticky ALU status for debug.
module alu_exception_unit #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [3:0]       alu_control,
  input  logic [7:0]       alu_status,
  input  logic [PC_W-1:0]  pc_in,
  input  logic [2:0]       exc_en,
  input  logic             exc_ack,
  input  logic             exc_ret,
  input  logic             flag_clr,
  output logic             exc_req,
  output logic             flush,
  output logic [3:0]       cause,
  output logic [PC_W-1:0]  epc,
  output logic             in_handler,
  output logic [7:0]       sticky_flags,
  output logic [CNT_W-1:0] dropped_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  localparam logic [3:0] CTRL_DIV  = 4'd4;
  localparam logic [3:0] CTRL_MUL  = 4'd5;
  localparam logic [3:0] CTRL_LDW  = 4'd12;
  localparam logic [3:0] CTRL_LDWN = 4'd13;

  localparam logic [3:0] CAUSE_NONE     = 4'd0;
  localparam logic [3:0] CAUSE_DIVZ     = 4'd1;
  localparam logic [3:0] CAUSE_MISALIGN = 4'd2;
  localparam logic [3:0] CAUSE_MULOVF   = 4'd3;

  state_t r_state;
  state_t w_state_nxt;

  logic             w_divz;
  logic             w_misalign;
  logic             w_mulovf;
  logic             w_hit;
  logic [3:0]       w_cause;
  logic             w_capture;
  logic             w_drop;

  logic             r_flush;
  logic [3:0]       r_cause;
  logic [PC_W-1:0]  r_epc;
  logic [CNT_W-1:0] r_dropped;
  logic [7:0]       r_sticky;

  // Opcode 12 expects the align bit set, opcode 13 expects it clear.
  always_comb begin
    w_divz     = alu_valid && exc_en[0] && (alu_control == CTRL_DIV) && alu_status[2];
    w_misalign = alu_valid && exc_en[1] &&
                 (((alu_control == CTRL_LDW)  && !alu_status[3]) ||
                  ((alu_control == CTRL_LDWN) &&  alu_status[3]));
    w_mulovf   = alu_valid && exc_en[2] && (alu_control == CTRL_MUL) && alu_status[6];
    w_hit      = w_divz || w_misalign || w_mulovf;

    if (w_misalign)   w_cause = CAUSE_MISALIGN;
    else if (w_divz)  w_cause = CAUSE_DIVZ;
    else if (w_mulovf) w_cause = CAUSE_MULOVF;
    else              w_cause = CAUSE_NONE;
  end

  // NOTE: every signal driven here gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_drop      = 1'b0;
    exc_req     = 1'b0;
    in_handler  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          w_capture   = 1'b1;
          w_state_nxt = S_PENDING;
        end
      end
      S_PENDING: begin
        exc_req = 1'b1;
        w_drop  = w_hit;
        if (exc_ack) w_state_nxt = S_SERVICE;
      end
      S_SERVICE: begin
        in_handler = 1'b1;
        w_drop     = w_hit;
        if (exc_ret) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flush   <= 1'b0;
      r_cause   <= CAUSE_NONE;
      r_epc     <= '0;
      r_dropped <= '0;
      r_sticky  <= '0;
    end else begin
      r_flush <= w_capture;
      if (w_capture) begin
        r_cause <= w_cause;
        r_epc   <= pc_in;
      end
      if (w_drop && (r_dropped != {CNT_W{1'b1}}))
        r_dropped <= r_dropped + CNT_W'(1);
      // A clear and a new status in the same cycle keeps the new status.
      r_sticky <= (flag_clr ? 8'h00 : r_sticky) | (alu_valid ? alu_status : 8'h00);
    end
  end

  assign flush        = r_flush;
  assign cause        = r_cause;
  assign epc          = r_epc;
  assign dropped_cnt  = r_dropped;
  assign sticky_flags = r_sticky;

endmodule

// File: tb/tb_alu_exception_unit.sv
// Randomised plus directed bench for alu_exception_unit: a cycle-level reference model
// predicts every output; captured exceptions are queued and checked when flush pulses.
module tb_alu_exception_unit;

  localparam int PC_W  = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             alu_valid;
  logic [3:0]       alu_control;
  logic [7:0]       alu_status;
  logic [PC_W-1:0]  pc_in;
  logic [2:0]       exc_en;
  logic             exc_ack;
  logic             exc_ret;
  logic             flag_clr;
  logic             exc_req;
  logic             flush;
  logic [3:0]       cause;
  logic [PC_W-1:0]  epc;
  logic             in_handler;
  logic [7:0]       sticky_flags;
  logic [CNT_W-1:0] dropped_cnt;

  alu_exception_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_control  (alu_control),
    .alu_status   (alu_status),
    .pc_in        (pc_in),
    .exc_en       (exc_en),
    .exc_ack      (exc_ack),
    .exc_ret      (exc_ret),
    .flag_clr     (flag_clr),
    .exc_req      (exc_req),
    .flush        (flush),
    .cause        (cause),
    .epc          (epc),
    .in_handler   (in_handler),
    .sticky_flags (sticky_flags),
    .dropped_cnt  (dropped_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      cause;
    logic [PC_W-1:0] epc;
  } trap_t;

  trap_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: handler is either free, has a pending request, or is servicing one.
  bit              m_pending;
  bit              m_service;
  bit              m_flush;
  logic [3:0]      m_cause;
  logic [PC_W-1:0] m_epc;
  int              m_dropped;
  logic [7:0]      m_sticky;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pending = 0;
    m_service = 0;
    m_flush   = 0;
    m_cause   = 4'd0;
    m_epc     = '0;
    m_dropped = 0;
    m_sticky  = 8'h00;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".exc_req"},    64'(exc_req),      64'(m_pending));
    check({tag, ".in_handler"}, 64'(in_handler),   64'(m_service));
    check({tag, ".flush"},      64'(flush),        64'(m_flush));
    check({tag, ".cause"},      64'(cause),        64'(m_cause));
    check({tag, ".epc"},        64'(epc),          64'(m_epc));
    check({tag, ".dropped"},    64'(dropped_cnt),  64'(m_dropped));
    check({tag, ".sticky"},     64'(sticky_flags), 64'(m_sticky));
  endtask

  // Drive one cycle of inputs (called at a falling edge), predict, then check at the next falling edge.
  task automatic apply(input bit v, input logic [3:0] ctrl, input logic [7:0] st,
                       input logic [PC_W-1:0] pc, input logic [2:0] en,
                       input bit ack, input bit ret, input bit clr, input string tag);
    bit mis, dz, ov, hit, n_pend, n_serv, n_flush;
    logic [3:0] code;
    alu_valid = v; alu_control = ctrl; alu_status = st; pc_in = pc;
    exc_en = en; exc_ack = ack; exc_ret = ret; flag_clr = clr;

    mis = v && en[1] && ((ctrl == 4'd12 && !st[3]) || (ctrl == 4'd13 && st[3]));
    dz  = v && en[0] && ctrl == 4'd4 && st[2];
    ov  = v && en[2] && ctrl == 4'd5 && st[6];
    hit = mis || dz || ov;
    code = mis ? 4'd2 : dz ? 4'd1 : ov ? 4'd3 : 4'd0;

    n_pend = m_pending; n_serv = m_service; n_flush = 0;
    if (!m_pending && !m_service) begin
      if (hit) begin
        n_pend  = 1;
        n_flush = 1;
      end
    end else begin
      if (hit && m_dropped < (1 << CNT_W) - 1) m_dropped++;
      if (m_pending && ack) begin
        n_pend = 0;
        n_serv = 1;
      end else if (m_service && ret) begin
        n_serv = 0;
      end
    end

    @(posedge clk);
    if (n_flush) begin
      m_cause = code;
      m_epc   = pc;
      exp_q.push_back('{cause: code, epc: pc});
    end
    m_pending = n_pend;
    m_service = n_serv;
    m_flush   = n_flush;
    m_sticky  = (clr ? 8'h00 : m_sticky) | (v ? st : 8'h00);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    apply(0, 4'd0, 8'h00, '0, 3'b111, 0, 0, 0, tag);
  endtask

  // Monitor: every flush pulse must match the oldest captured exception.
  always @(negedge clk) begin
    if (reset === 1'b0 && flush === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("mon.flush_unexpected", 64'(flush), 64'd0);
      end else begin
        trap_t e;
        e = exp_q.pop_front();
        check("mon.cause", 64'(cause), 64'(e.cause));
        check("mon.epc",   64'(epc),   64'(e.epc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    alu_valid = 0; alu_control = 0; alu_status = 0; pc_in = 0;
    exc_en = 0; exc_ack = 0; exc_ret = 0; flag_clr = 0;
    model_reset();
    @(negedge clk);
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    idle("post_reset");

    // Divide-by-zero: request, ack into service, return.
    apply(1, 4'd4, 8'h04, 32'h40, 3'b111, 0, 0, 0, "divz_hit");
    idle("divz_pending");
    apply(0, 4'd0, 8'h00, '0, 3'b111, 1, 0, 0, "divz_ack");
    apply(0, 4'd0, 8'h00, '0, 3'b111, 0, 1, 0, "divz_ret");
    idle("divz_idle");

    // Misaligned word accesses and enable gating.
    apply(1, 4'd12, 8'h00, 32'h104, 3'b111, 0, 0, 0, "mis12_hit");
    apply(0, 4'd0, 8'h00, '0, 3'b111, 1, 0, 0, "mis12_ack");
    apply(0, 4'd0, 8'h00, '0, 3'b111, 0, 1, 0, "mis12_ret");
    apply(1, 4'd13, 8'h00, 32'h108, 3'b111, 0, 0, 0, "mis13_nohit");
    apply(1, 4'd13, 8'h08, 32'h10c, 3'b111, 0, 0, 0, "mis13_hit");
    apply(0, 4'd0, 8'h00, '0, 3'b111, 1, 1, 0, "ack_ret_same");
    apply(0, 4'd0, 8'h00, '0, 3'b111, 0, 1, 0, "mis13_ret");
    apply(1, 4'd12, 8'h00, 32'h110, 3'b101, 0, 0, 0, "mis_disabled");

    // Priority: misaligned beats div-by-zero is impossible on one opcode, so
    // check div-by-zero on the ack cycle is dropped rather than captured.
    apply(1, 4'd5, 8'h40, 32'h200, 3'b111, 0, 0, 0, "mulovf_hit");
    apply(1, 4'd4, 8'h04, 32'h204, 3'b111, 1, 0, 0, "hit_on_ack");
    apply(1, 4'd5, 8'h40, 32'h208, 3'b111, 0, 0, 0, "hit_in_service");
    for (int i = 0; i < 300; i++)
      apply(1, 4'd5, 8'h40, 32'h300 + 32'(i), 3'b111, 0, 0, 0, "drop_sat");
    apply(1, 4'd4, 8'h04, 32'h400, 3'b111, 0, 1, 0, "hit_on_ret");
    idle("after_ret");

    // Wrong opcode never traps but still feeds sticky flags.
    apply(1, 4'd0, 8'h00, '0, 3'b111, 0, 0, 1, "sticky_clear");
    apply(1, 4'd2, 8'h44, 32'h500, 3'b111, 0, 0, 0, "wrong_code");
    apply(0, 4'd4, 8'h04, 32'h504, 3'b111, 0, 0, 0, "invalid_op");
    apply(1, 4'd0, 8'h80, 32'h508, 3'b111, 0, 0, 1, "clr_and_new");

    // Reset while a request is pending drops everything immediately.
    apply(1, 4'd4, 8'h04, 32'h600, 3'b111, 0, 0, 0, "pre_reset_hit");
    idle("pre_reset_pending");
    reset = 1'b1;
    #1;
    model_reset();
    exp_q.delete();
    check_outputs("async_reset");
    @(negedge clk);
    check_outputs("held_reset");
    reset = 1'b0;
    idle("after_async_reset");

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] ctrl;
      logic [2:0] en;
      case ($urandom_range(0, 5))
        0: ctrl = 4'd4;
        1: ctrl = 4'd5;
        2: ctrl = 4'd12;
        3: ctrl = 4'd13;
        default: ctrl = 4'($urandom);
      endcase
      en = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      apply($urandom_range(0, 3) != 0, ctrl, 8'($urandom), 32'($urandom), en,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, "random");
    end

    idle("drain");
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
